// File: rtl/adder_pkg.sv
// adder_pkg: shared types and constants for the adder result path.
package adder_pkg;
    localparam int SUM_W     = 8;
    localparam int DEPTH_DEF = 4;

    typedef struct packed {
        logic             carry;
        logic [SUM_W-1:0] sum;
    } result_t;

    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int LEVEL_W = level_w(DEPTH_DEF);
endpackage

// File: rtl/adder_result_ram.sv
// adder_result_ram: DEPTH x result_t register array, registered write, asynchronous read.
module adder_result_ram #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  adder_pkg::result_t       wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output adder_pkg::result_t       rdata
);
    import adder_pkg::*;

    result_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/adder_result_fifo.sv
// adder_result_fifo: buffers {carry, sum} adder results behind a valid/ready handshake,
// with a saturating overflow counter and a sticky drop flag.
module adder_result_fifo #(
    parameter int DEPTH = 4,
    parameter int SUM_W = adder_pkg::SUM_W,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic                   clr,
    input  logic                   in_valid,
    input  logic [SUM_W-1:0]       in_sum,
    input  logic                   in_carry,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [SUM_W:0]         out_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   full,
    output logic                   empty,
    output logic [CNT_W-1:0]       ovf_count,
    output logic                   dropped
);
    import adder_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int LW = level_w(DEPTH);

    logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic [CNT_W-1:0] ovf_q, ovf_d;
    logic             dropped_q, dropped_d;
    logic             pop, push, we;
    result_t          wdata, rdata;

    assign level     = level_q;
    assign full      = level_q == LW'(DEPTH);
    assign empty     = level_q == '0;
    assign out_valid = !empty;
    assign out_data  = empty ? '0 : rdata;
    assign ovf_count = ovf_q;
    assign dropped   = dropped_q;

    assign pop   = out_valid & out_ready;
    assign push  = in_valid & (!full | pop);
    assign wdata = '{carry: in_carry, sum: in_sum};

    // When full with a pop, the write lands in the slot the head is leaving.
    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        level_d   = level_q;
        ovf_d     = ovf_q;
        dropped_d = dropped_q;
        we        = 1'b0;
        if (ena && clr) begin
            wptr_d    = '0;
            rptr_d    = '0;
            level_d   = '0;
            ovf_d     = '0;
            dropped_d = 1'b0;
        end else if (ena) begin
            we        = push;
            wptr_d    = wptr_q + PW'(push);
            rptr_d    = rptr_q + PW'(pop);
            level_d   = level_q + LW'(push) - LW'(pop);
            ovf_d     = (push && in_carry && ovf_q != '1) ? ovf_q + CNT_W'(1) : ovf_q;
            dropped_d = dropped_q | (in_valid & full & ~pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            level_q   <= '0;
            ovf_q     <= '0;
            dropped_q <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            level_q   <= level_d;
            ovf_q     <= ovf_d;
            dropped_q <= dropped_d;
        end
    end

    adder_result_ram #(.DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wptr_q),
        .wdata (wdata),
        .raddr (rptr_q),
        .rdata (rdata)
    );
endmodule

// File: tb/tb_adder_result_fifo.sv
// tb_adder_result_fifo: directed + random stimulus checked every cycle against a queue model.
module tb_adder_result_fifo;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_sum = '0;
    logic       in_carry = 1'b0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [8:0] out_data;
    logic [2:0] level;
    logic       full, empty;
    logic [7:0] ovf_count;
    logic       dropped;

    int checks = 0;
    int errors = 0;

    adder_result_fifo dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clr(clr),
        .in_valid(in_valid), .in_sum(in_sum), .in_carry(in_carry),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .level(level), .full(full), .empty(empty),
        .ovf_count(ovf_count), .dropped(dropped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of at most 4 entries plus counter and flag.
    logic [8:0] mq[$];
    int         m_ovf = 0;
    bit         m_drop = 0;
    bit         m_pop, m_push;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_ovf  = 0;
            m_drop = 0;
        end else if (ena) begin
            if (clr) begin
                mq.delete();
                m_ovf  = 0;
                m_drop = 0;
            end else begin
                m_pop  = mq.size() > 0 && out_ready;
                m_push = in_valid && (mq.size() < 4 || m_pop);
                if (in_valid && mq.size() == 4 && !m_pop) m_drop = 1;
                if (m_pop) void'(mq.pop_front());
                if (m_push) begin
                    mq.push_back({in_carry, in_sum});
                    if (in_carry && m_ovf < 255) m_ovf++;
                end
            end
        end
    end

    always @(posedge clk) begin
        #2;
        chk("m_out_valid", out_valid, mq.size() > 0);
        chk("m_out_data", out_data, mq.size() > 0 ? mq[0] : 9'h000);
        chk("m_level", level, mq.size());
        chk("m_full", full, mq.size() == 4);
        chk("m_empty", empty, mq.size() == 0);
        chk("m_ovf_count", ovf_count, m_ovf);
        chk("m_dropped", dropped, m_drop);
    end

    task automatic drive(input logic v, input logic [8:0] d, input logic r);
        in_valid  = v;
        {in_carry, in_sum} = d;
        out_ready = r;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_empty", empty, 1);
        chk("rst_level", level, 0);
        rst_n = 1'b1;
        drive(1, 9'h002, 0);
        chk("t1_valid", out_valid, 1);
        chk("t1_data", out_data, 9'h002);
        chk("t1_level", level, 1);
        drive(0, 9'h000, 1);
        chk("t1_empty", empty, 1);
        chk("t1_data0", out_data, 9'h000);

        drive(1, 9'h010, 0);
        drive(1, 9'h100, 0);
        drive(1, 9'h0FF, 0);
        chk("t2_level", level, 3);
        chk("t2_ovf", ovf_count, 1);
        chk("t2_d0", out_data, 9'h010);
        drive(0, 9'h000, 1);
        chk("t2_d1", out_data, 9'h100);
        drive(0, 9'h000, 1);
        chk("t2_d2", out_data, 9'h0FF);
        drive(0, 9'h000, 1);
        chk("t2_empty", empty, 1);

        for (int i = 1; i <= 4; i++) drive(1, 9'(i), 0);
        chk("t3_full", full, 1);
        drive(1, 9'h1AB, 0);
        chk("t3_dropped", dropped, 1);
        chk("t3_level", level, 4);
        chk("t3_ovf", ovf_count, 1);
        drive(1, 9'h055, 1);
        chk("t3_level_pp", level, 4);
        chk("t3_head", out_data, 9'h002);
        drive(0, 9'h000, 1);
        chk("t3_d3", out_data, 9'h003);
        drive(0, 9'h000, 1);
        chk("t3_d4", out_data, 9'h004);
        drive(0, 9'h000, 1);
        chk("t3_tail", out_data, 9'h055);
        drive(0, 9'h000, 1);
        chk("t3_empty", empty, 1);

        for (int i = 0; i < 260; i++) drive(1, {1'b1, 8'(i)}, 1);
        chk("t4_sat", ovf_count, 8'hFF);
        drive(0, 9'h000, 1);

        drive(1, 9'h011, 0);
        drive(1, 9'h022, 0);
        chk("t5_level2", level, 2);
        clr = 1'b1;
        drive(1, 9'h1EE, 0);
        clr = 1'b0;
        chk("t5_level", level, 0);
        chk("t5_empty", empty, 1);
        chk("t5_ovf", ovf_count, 0);
        chk("t5_dropped", dropped, 0);
        chk("t5_valid", out_valid, 0);

        drive(1, 9'h1C3, 0);
        drive(1, 9'h034, 0);
        ena = 1'b0;
        repeat (3) drive(1, 9'h1FF, 1);
        chk("t6_level", level, 2);
        chk("t6_data", out_data, 9'h1C3);
        chk("t6_ovf", ovf_count, 1);
        ena = 1'b1;

        for (int i = 0; i < 2000; i++) begin
            ena = $urandom_range(9) != 0;
            clr = $urandom_range(29) == 0;
            drive(1'($urandom_range(3) != 0), 9'($urandom), 1'($urandom_range(2) == 0));
        end
        clr = 1'b0;
        ena = 1'b1;
        drive(1, 9'h1AA, 0);
        drive(1, 9'h1BB, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("r_valid", out_valid, 0);
        chk("r_data", out_data, 0);
        chk("r_level", level, 0);
        chk("r_full", full, 0);
        chk("r_empty", empty, 1);
        chk("r_ovf", ovf_count, 0);
        chk("r_dropped", dropped, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) drive(0, 9'h000, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
